// File: rtl/io_bus_arb.sv
// Two-master round-robin arbiter for the shared IO decoder port, with an optional
// bounded lock that lets one master keep the port for read-modify-write sequences.
module io_bus_arb #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        io_ce,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_din,
  input  logic [31:0] io_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic       lat_lock;
  logic       owner_valid;
  logic       owner;
  logic [3:0] beat_cnt;

  logic       owner_req;
  logic       grant_any;
  logic       pick;

  // A valid owner that still requests pre-empts round-robin; otherwise alternate on ties.
  always_comb begin
    owner_req = owner ? m1_req : m0_req;
    grant_any = 1'b0;
    pick      = 1'b0;
    if (owner_valid && owner_req) begin
      grant_any = 1'b1;
      pick      = owner;
    end else if (m0_req && m1_req) begin
      grant_any = 1'b1;
      pick      = ~last_grant;
    end else if (m0_req) begin
      grant_any = 1'b1;
      pick      = 1'b0;
    end else if (m1_req) begin
      grant_any = 1'b1;
      pick      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      io_ce       <= 1'b0;
      io_we       <= 1'b0;
      io_addr     <= '0;
      io_din      <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      lat_lock    <= 1'b0;
      owner_valid <= 1'b0;
      owner       <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      io_ce  <= 1'b0;
      io_we  <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (owner_valid && !owner_req) begin
            owner_valid <= 1'b0;
            beat_cnt    <= '0;
          end
          if (grant_any) begin
            gnt        <= pick;
            last_grant <= pick;
            io_ce      <= 1'b1;
            io_we      <= pick ? m1_we    : m0_we;
            io_addr    <= pick ? m1_addr  : m0_addr;
            io_din     <= pick ? m1_wdata : m0_wdata;
            lat_lock   <= pick ? m1_lock  : m0_lock;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // io_we still holds the latched direction during this cycle.
          if (!io_we) begin
            if (gnt) m1_rdata <= io_dout;
            else     m0_rdata <= io_dout;
          end
          if (gnt) m1_ack <= 1'b1;
          else     m0_ack <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (lat_lock && (beat_cnt + 4'd1 < LOCK_LIM)) begin
            owner_valid <= 1'b1;
            owner       <= gnt;
            beat_cnt    <= beat_cnt + 4'd1;
          end else begin
            owner_valid <= 1'b0;
            beat_cnt    <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arb.sv
// Scoreboard bench for io_bus_arb: expected accesses are queued in grant order when
// stimulus starts and retired against io_ce strobes and acks.
module tb_io_bus_arb;

  typedef struct packed {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [31:0] rdata [2];
  logic        io_ce;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_din;
  logic [31:0] io_dout;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastAck = -1;
  bit   gapChk = 1'b0;
  bit [1:0] autoEn = 2'b00;
  int   cnt[2];
  int   limit[2];
  int   lockCnt[2];
  int   expK[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] ioModel(input logic [31:0] a);
    return (a == 32'h0000E000) ? 32'hAABBCCDD : (a ^ 32'h5A5A5A5A);
  endfunction

  assign io_dout = ioModel(io_addr);

  io_bus_arb #(.LOCK_MAX(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_lock  (lock[0]),
    .m0_ack   (ack[0]),
    .m0_rdata (rdata[0]),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_lock  (lock[1]),
    .m1_ack   (ack[1]),
    .m1_rdata (rdata[1]),
    .io_ce    (io_ce),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_dout  (io_dout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Access k of master m: even k reads, odd k writes, distinct address per access.
  function automatic exp_t makeItem(input int m, input int k);
    exp_t e;
    e.mst   = (m != 0);
    e.we    = (k % 2) == 1;
    e.addr  = ((m != 0) ? 32'h00002000 : 32'h00001000) + 32'(k * 4);
    e.wdata = 32'hC0DE0000 + 32'(m * 4096) + 32'(k);
    return e;
  endfunction

  task automatic applyStimulus(input int m, input int k);
    exp_t e;
    e        = makeItem(m, k);
    we[m]    = e.we;
    addr[m]  = e.addr;
    wdata[m] = e.wdata;
    lock[m]  = (k < lockCnt[m]);
  endtask

  task automatic startMaster(input int m, input int lim, input int lk);
    cnt[m]     = 0;
    limit[m]   = lim;
    lockCnt[m] = lk;
    expK[m]    = 0;
    applyStimulus(m, 0);
    req[m]    = 1'b1;
    autoEn[m] = 1'b1;
  endtask

  task automatic pushExp(input int m);
    expQ.push_back(makeItem(m, expK[m]));
    expK[m]++;
  endtask

  task automatic monitor();
    exp_t e;
    if (ack == 2'b11) checkOutput("dual_ack", 32'(ack), 32'd0);
    if (io_we && !io_ce) checkOutput("we_without_ce", 32'(io_we), 32'd0);
    if (io_ce) begin
      if (expQ.size() == 0) checkOutput("unexpected_ce", 32'(io_ce), 32'd0);
      else begin
        checkOutput("ce_addr", io_addr, expQ[0].addr);
        checkOutput("ce_we", 32'(io_we), 32'(expQ[0].we));
        if (expQ[0].we) checkOutput("ce_din", io_din, expQ[0].wdata);
      end
    end
    if (ack != 2'b00) begin
      if (expQ.size() == 0) checkOutput("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = expQ.pop_front();
        checkOutput("ack_master", 32'(ack), e.mst ? 32'd2 : 32'd1);
        if (!e.we) checkOutput("rdata", e.mst ? rdata[1] : rdata[0], ioModel(e.addr));
        if (gapChk && lastAck >= 0) checkOutput("ack_gap", 32'(cyc - lastAck), 32'd3);
        lastAck = cyc;
      end
    end
  endtask

  // One cycle: sample at the falling edge, then let the masters react to their acks.
  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    for (int m = 0; m < 2; m++) begin
      if (autoEn[m] && ack[m]) begin
        cnt[m]++;
        if (cnt[m] >= limit[m]) begin
          req[m]    = 1'b0;
          lock[m]   = 1'b0;
          autoEn[m] = 1'b0;
        end else begin
          applyStimulus(m, cnt[m]);
        end
      end
    end
  endtask

  task automatic runUntilDone(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || autoEn != 2'b00) && n < maxCycles) begin
      step();
      n++;
    end
    if (n >= maxCycles) checkOutput("timeout", 32'(expQ.size()), 32'd0);
    repeat (4) step();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_io_ce"}, 32'(io_ce), 32'd0);
    checkOutput({tag, "_io_we"}, 32'(io_we), 32'd0);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_io_addr"}, io_addr, 32'd0);
    checkOutput({tag, "_io_din"}, io_din, 32'd0);
    checkOutput({tag, "_m0_rdata"}, rdata[0], 32'd0);
    checkOutput({tag, "_m1_rdata"}, rdata[1], 32'd0);
  endtask

  task automatic resetDut();
    rst_n  = 1'b0;
    req    = 2'b00;
    autoEn = 2'b00;
    step();
    step();
    rst_n  = 1'b1;
    expQ.delete();
    lastAck = -1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 2'b00;
    we       = 2'b00;
    lock     = 2'b00;
    addr[0]  = '0;
    addr[1]  = '0;
    wdata[0] = '0;
    wdata[1] = '0;

    $display("[TB] reset and single write");
    step();
    checkResetOutputs("reset");
    resetDut();
    we[0] = 1'b1; addr[0] = 32'h0000F000; wdata[0] = 32'h12345678; lock[0] = 1'b0;
    req[0] = 1'b1;
    expQ.push_back(exp_t'{1'b0, 1'b1, 32'h0000F000, 32'h12345678});
    step();
    checkOutput("wr_ce", 32'(io_ce), 32'd1);
    checkOutput("wr_we", 32'(io_we), 32'd1);
    checkOutput("wr_ack_early", 32'(ack), 32'd0);
    step();
    checkOutput("wr_ack", 32'(ack), 32'd1);
    checkOutput("wr_ce_off", 32'(io_ce), 32'd0);
    req[0] = 1'b0;
    step();
    checkOutput("wr_ack_off", 32'(ack), 32'd0);
    checkOutput("wr_ce_idle", 32'(io_ce), 32'd0);
    checkOutput("wr_q_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] read capture");
    we[1] = 1'b0; addr[1] = 32'h0000E000; wdata[1] = 32'h0; lock[1] = 1'b0;
    req[1] = 1'b1;
    expQ.push_back(exp_t'{1'b1, 1'b0, 32'h0000E000, 32'h0});
    step();
    checkOutput("rd_ce", 32'(io_ce), 32'd1);
    checkOutput("rd_we", 32'(io_we), 32'd0);
    step();
    checkOutput("rd_ack", 32'(ack), 32'd2);
    checkOutput("rd_m1_rdata", rdata[1], 32'hAABBCCDD);
    checkOutput("rd_m0_rdata", rdata[0], 32'd0);
    req[1] = 1'b0;
    step();
    checkOutput("rd_we_after", 32'(io_we), 32'd0);

    $display("[TB] reset during an m1 read");
    startMaster(1, 1, 0);
    pushExp(1);
    begin
      int n;
      n = 0;
      while (!io_ce && n < 10) begin
        step();
        n++;
      end
      checkOutput("rst_issue_seen", 32'(io_ce), 32'd1);
    end
    rst_n  = 1'b0;
    req    = 2'b00;
    autoEn = 2'b00;
    step();
    checkResetOutputs("midrst");
    checkOutput("midrst_abandoned", 32'(expQ.size()), 32'd1);
    expQ.delete();
    rst_n = 1'b1;
    startMaster(0, 1, 0);
    startMaster(1, 1, 0);
    pushExp(0);
    pushExp(1);
    runUntilDone(100);

    $display("[TB] round-robin");
    resetDut();
    gapChk = 1'b1;
    startMaster(0, 4, 0);
    startMaster(1, 4, 0);
    for (int i = 0; i < 4; i++) begin
      pushExp(0);
      pushExp(1);
    end
    runUntilDone(200);
    gapChk = 1'b0;

    $display("[TB] lock bound");
    resetDut();
    startMaster(0, 12, 8);
    startMaster(1, 6, 0);
    for (int i = 0; i < 8; i++) pushExp(0);
    for (int i = 0; i < 4; i++) begin
      pushExp(1);
      pushExp(0);
    end
    pushExp(1);
    pushExp(1);
    runUntilDone(300);

    $display("[TB] lock release by req drop");
    resetDut();
    startMaster(0, 2, 2);
    startMaster(1, 1, 0);
    pushExp(0);
    pushExp(0);
    pushExp(1);
    runUntilDone(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arb.md
# io_bus_arb

Two-master arbiter sharing the single IO decoder port (LED, RGB LED, 7-segment and timer registers) between the CPU data-memory path (master 0) and the debug/loader port (master 1). It accepts word requests from each master, selects one by round-robin, drives one registered access cycle onto the IO port, captures the read data, and returns a one-cycle acknowledge. An optional lock keeps the grant for back-to-back read-modify-write sequences, bounded by a beat limit.

## Interface
- LOCK_MAX, 8: maximum consecutive accesses one master may hold under lock; range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- m0_req / m1_req  in  1  access request; held until the matching ack.
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr / m1_addr  in  32  IO byte address; stable while req is high.
- m0_wdata / m1_wdata  in  32  write data, raw bus order with no swap here.
- m0_lock / m1_lock  in  1  keep the grant after this access.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data; valid in the ack cycle and held until the next ack to that master.
- io_ce  out  1  IO access strobe.
- io_we  out  1  IO write enable; only ever high together with io_ce.
- io_addr  out  32  IO address.
- io_din  out  32  IO write data.
- io_dout  in  32  IO read data; combinational from io_addr.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive the port.
  - RESP: pulse ack.
- IDLE arbitration:
  - If the lock owner is valid, only the owner can be granted. The other master waits.
  - Otherwise, with one requester, grant it.
  - With both requesting, grant the master not granted last (last_grant pointer).
  - With no request, stay in IDLE.
- On grant:
  - Latch the winner's we/addr/wdata/lock into the port registers.
  - Update last_grant.
  - Go to ISSUE.
- ISSUE:
  - io_ce=1 and io_we=latched we for exactly one cycle.
  - io_dout is captured into the granted master's rdata register at the end of this cycle, for reads only. Writes leave rdata unchanged.
  - Go to RESP.
- RESP:
  - Granted master's ack=1 for one cycle; io_ce=0.
  - Update the lock: if the latched lock is 1, set owner=granted master and increment beat_cnt.
  - If the latched lock is 0, or beat_cnt reaches LOCK_MAX, clear the owner and beat_cnt to 0.
  - Go to IDLE.
- Owner release: if in IDLE the owner's req=0, the owner is cleared.
- Masters must deassert req in the ack cycle unless issuing a new access. A req still high in IDLE after RESP is treated as a new access.
- No data transformation; byte ordering remains the IO decoder's concern.

## Timing
- Reset values:
  - State IDLE; io_ce, io_we, m0_ack, m1_ack = 0.
  - io_addr, io_din, m0_rdata, m1_rdata = 0.
  - last_grant=1, so master 0 wins the first tie.
  - Lock owner invalid, beat_cnt=0.
- Latency: req seen high at edge N produces io_ce high during cycle N+1 and ack high during cycle N+2.
  - Minimum 3 cycles per access; peak throughput one access per 3 cycles.
- Tie at IDLE: alternate strictly m0, m1, m0, ... while both hold req and no lock is active.
- Locked sequence: the owner is granted on every IDLE while its req is high, up to LOCK_MAX accesses.
  - After the LOCK_MAX-th ack, lock is released.
  - If the other master is waiting, it wins the next IDLE, then normal round-robin resumes.
- A req rising during ISSUE/RESP is not dropped: it is arbitrated at the next IDLE.
- Reset asserted mid-access (ISSUE or RESP):
  - Next edge returns to reset values.
  - No ack is issued; in-flight access is abandoned.
  - A write already strobed in ISSUE has taken effect in the IO decoder.
- io_addr/io_din hold their last values outside ISSUE; only io_ce/io_we qualify them.

## Test plan
- Reset/single write: m0 writes 0x0000F000 with data 0x12345678 (m0_lock=0).
  - io_ce=io_we=1 exactly one cycle, with io_addr=0x0000F000 and io_din=0x12345678.
  - m0_ack pulses 2 cycles after req; m1_ack stays 0.
- Read capture: m1 reads 0x0000E000 while the IO model returns 0xAABBCCDD in ISSUE.
  - m1_rdata=0xAABBCCDD at m1_ack; m0_rdata is unchanged.
  - io_we=0 throughout.
- Round-robin: m0 and m1 request continuously from reset, no lock.
  - Grants alternate m0, m1, m0, m1, one ack every 3 cycles.
  - Never two acks in the same cycle.
- Lock bound (LOCK_MAX=8): m0 holds req+lock for 12 accesses while m1 requests throughout.
  - m0 receives 8 acks, then m1 receives one.
  - After that, m0 and m1 alternate.
- Lock release by req drop: m0 does 2 locked accesses, then drops req in IDLE while m1 is waiting.
  - m1 is granted on that IDLE; lock owner is cleared.
- Reset mid-access: assert rst_n=0 in the ISSUE cycle of an m1 read.
  - Next cycle, all outputs are at reset values with no ack.
  - After release, a simultaneous m0/m1 request grants m0 first.
